// File: rtl/e203_ifu_jalr_sched.sv
// e203_ifu_jalr_sched: IFU branch prediction operands and JALR rs1 read scheduling
// via the shared regfile port.
module e203_ifu_jalr_sched (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dec_i_valid,
   input  logic        dec_jal,
   input  logic        dec_jalr,
   input  logic        dec_bxx,
   input  logic [4:0]  dec_jalr_rs1idx,
   input  logic [31:0] dec_bjp_imm,
   input  logic [31:0] pc,
   input  logic        ifu_accept,
   input  logic        flush_req,
   input  logic        oitf_empty,
   input  logic        ir_valid,
   input  logic        ir_rdwen,
   input  logic [4:0]  ir_rdidx,
   input  logic [31:0] rf_x1,
   output logic        rs1_rd_req,
   input  logic        rs1_rd_gnt,
   input  logic [31:0] rs1_rd_data,
   output logic [4:0]  rs1_rd_idx,
   output logic        prdt_taken,
   output logic [31:0] prdt_op1,
   output logic [31:0] prdt_op2,
   output logic        bpu_wait
);
   localparam logic [1:0] IDLE = 2'd0, WAIT_DEP = 2'd1, REQ = 2'd2, CAPT = 2'd3;
   logic [1:0]  state, state_nxt;
   logic [31:0] rs1_buf;
   logic        jalr_x0, jalr_x1, jalr_xn, ir_wr, x1_dep, xn_dep;
   assign jalr_x0 = dec_jalr & (dec_jalr_rs1idx == 5'd0);
   assign jalr_x1 = dec_jalr & (dec_jalr_rs1idx == 5'd1);
   assign jalr_xn = dec_jalr & (|dec_jalr_rs1idx[4:1]);
   assign ir_wr   = ir_valid & ir_rdwen;
   assign x1_dep  = ~oitf_empty | (ir_wr & (ir_rdidx == 5'd1));
   assign xn_dep  = ~oitf_empty | (ir_wr & (ir_rdidx == dec_jalr_rs1idx));
   always_comb begin
      state_nxt = flush_req            ? IDLE :
                  (state == IDLE)      ? ((dec_i_valid & jalr_xn) ? (xn_dep ? WAIT_DEP : REQ) : IDLE) :
                  (state == WAIT_DEP)  ? (xn_dep ? WAIT_DEP : REQ) :
                  (state == REQ)       ? (rs1_rd_gnt ? CAPT : REQ) :
                                         (ifu_accept ? IDLE : CAPT);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         rs1_buf <= '0;
      end else begin
         state <= state_nxt;
         if ((state == REQ) & rs1_rd_gnt & ~flush_req) rs1_buf <= rs1_rd_data;
      end
   end
   assign rs1_rd_req = (state == REQ);
   assign rs1_rd_idx = dec_jalr_rs1idx;
   assign prdt_taken = dec_jal | dec_jalr | (dec_bxx & dec_bjp_imm[31]);
   assign prdt_op2   = dec_bjp_imm;
   assign prdt_op1   = ~dec_jalr ? pc : jalr_x0 ? 32'd0 : jalr_x1 ? rf_x1 : rs1_buf;
   // x1 waits purely on the live dependency; xN waits until its operand is captured
   assign bpu_wait   = (dec_i_valid & jalr_x1 & x1_dep)
                     | ((state == IDLE) & dec_i_valid & jalr_xn)
                     | (state == WAIT_DEP) | (state == REQ);
endmodule

// File: tb/tb_e203_ifu_jalr_sched.sv
// tb_e203_ifu_jalr_sched: scoreboard bench for the JALR scheduler; the driver
// queues expected predictions, a negedge monitor checks each accepted one.
module tb_e203_ifu_jalr_sched;
   logic        clk = 0, rst_n = 0;
   logic        dec_i_valid = 0, dec_jal = 0, dec_jalr = 0, dec_bxx = 0;
   logic [4:0]  dec_jalr_rs1idx = 0, ir_rdidx = 0;
   logic [31:0] dec_bjp_imm = 0, pc = 0, rf_x1 = 0, rs1_rd_data = 0;
   logic        ifu_accept = 0, flush_req = 0, oitf_empty = 1;
   logic        ir_valid = 0, ir_rdwen = 0, rs1_rd_gnt = 0;
   logic        rs1_rd_req, prdt_taken, bpu_wait;
   logic [4:0]  rs1_rd_idx;
   logic [31:0] prdt_op1, prdt_op2;
   logic [31:0] last_buf = 0;
   int          checks = 0, errors = 0;
   typedef struct {logic taken; logic [31:0] op1; logic [31:0] op2;} pred_t;
   pred_t exp_q[$];

   e203_ifu_jalr_sched dut (
      .clk(clk), .rst_n(rst_n), .dec_i_valid(dec_i_valid), .dec_jal(dec_jal),
      .dec_jalr(dec_jalr), .dec_bxx(dec_bxx), .dec_jalr_rs1idx(dec_jalr_rs1idx),
      .dec_bjp_imm(dec_bjp_imm), .pc(pc), .ifu_accept(ifu_accept), .flush_req(flush_req),
      .oitf_empty(oitf_empty), .ir_valid(ir_valid), .ir_rdwen(ir_rdwen), .ir_rdidx(ir_rdidx),
      .rf_x1(rf_x1), .rs1_rd_req(rs1_rd_req), .rs1_rd_gnt(rs1_rd_gnt), .rs1_rd_data(rs1_rd_data),
      .rs1_rd_idx(rs1_rd_idx), .prdt_taken(prdt_taken), .prdt_op1(prdt_op1),
      .prdt_op2(prdt_op2), .bpu_wait(bpu_wait)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every prediction the IFU accepts is matched against the queue
   always @(negedge clk) begin
      if (rst_n && dec_i_valid && ifu_accept) begin
         if (exp_q.size() == 0) chk("pred_unexpected", 32'd1, 32'd0);
         else begin
            pred_t e;
            e = exp_q.pop_front();
            chk("pred_taken", {31'd0, prdt_taken}, {31'd0, e.taken});
            chk("pred_op1", prdt_op1, e.op1);
            chk("pred_op2", prdt_op2, e.op2);
            chk("pred_wait", {31'd0, bpu_wait}, 32'd0);
         end
      end
   end

   // kind: 0 jal, 1 bxx, 2 jalr. Called just after a posedge.
   task automatic issue(input int kind, input logic [4:0] idx, input logic [31:0] imm,
                        input logic [31:0] pcv, input int dep, input bit use_ir,
                        input int gdly, input logic [31:0] data);
      pred_t e;
      int waits = 0, reqs = 0, cyc = 0, exp_wait, exp_req;
      logic [31:0] x1v;
      x1v = $urandom;
      e.taken = (kind != 1) || imm[31];
      e.op2 = imm;
      e.op1 = (kind != 2) ? pcv : (idx == 0) ? 32'd0 : (idx == 1) ? x1v : data;
      exp_q.push_back(e);
      exp_wait = (kind != 2 || idx == 0) ? 0 : (idx == 1) ? dep : dep + gdly + 2;
      exp_req  = (kind == 2 && idx >= 2) ? gdly + 1 : 0;
      rf_x1 = x1v; pc = pcv; dec_bjp_imm = imm; dec_jalr_rs1idx = idx;
      dec_jal = (kind == 0); dec_bxx = (kind == 1); dec_jalr = (kind == 2);
      dec_i_valid = 1;
      forever begin
         oitf_empty = !(cyc < dep && !use_ir);
         ir_valid = (cyc < dep) && use_ir;
         ir_rdwen = ir_valid;
         ir_rdidx = idx;
         rs1_rd_gnt = 0;
         rs1_rd_data = $urandom;
         #1;
         if (rs1_rd_req) begin
            chk("rd_idx", {27'd0, rs1_rd_idx}, {27'd0, idx});
            if (reqs >= gdly) begin rs1_rd_gnt = 1; rs1_rd_data = data; end
            reqs++;
         end
         #1;
         ifu_accept = !bpu_wait;
         if (bpu_wait) waits++;
         @(posedge clk); #1;
         cyc++;
         if (ifu_accept) break;
         if (cyc > 100) begin chk("issue_timeout", 32'd1, 32'd0); break; end
      end
      ifu_accept = 0; dec_i_valid = 0; rs1_rd_gnt = 0; oitf_empty = 1; ir_valid = 0; ir_rdwen = 0;
      chk("wait_cycles", waits, exp_wait);
      chk("req_cycles", reqs, exp_req);
      if (kind == 2 && idx >= 2) last_buf = data;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      dec_jalr = 1; dec_jalr_rs1idx = 5'd3;
      #3;
      chk("rst_req", {31'd0, rs1_rd_req}, 32'd0);
      chk("rst_wait", {31'd0, bpu_wait}, 32'd0);
      chk("rst_buf", prdt_op1, 32'd0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      dec_jalr = 0;
      issue(0, 5'd0, 32'h20, 32'h100, 0, 0, 0, 0);
      issue(1, 5'd0, 32'hFFFF_FFF0, 32'h200, 0, 0, 0, 0);
      issue(1, 5'd0, 32'h10, 32'h300, 0, 0, 0, 0);
      issue(2, 5'd0, 32'h80, 32'h400, 0, 0, 0, 0);
      issue(2, 5'd1, 32'h4, 32'h500, 3, 1, 0, 0);
      issue(2, 5'd5, 32'h8, 32'h600, 2, 0, 1, 32'h8000_0040);
      for (int i = 0; i < 60; i++) begin
         int kind;
         logic [4:0] idx;
         kind = $urandom_range(0, 2);
         idx = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 1)) : 5'($urandom_range(0, 31));
         issue(kind, idx, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               $urandom_range(0, 3), $urandom);
      end
      // flush in REQ together with a grant: grant dropped, request withdrawn
      issue(2, 5'd6, 32'h0, 32'h700, 0, 0, 0, 32'h1234_5678);
      dec_jalr = 1; dec_jalr_rs1idx = 5'd7; dec_i_valid = 1; dec_bjp_imm = 32'h40;
      @(posedge clk); #1;
      chk("flush_pre_req", {31'd0, rs1_rd_req}, 32'd1);
      chk("flush_pre_wait", {31'd0, bpu_wait}, 32'd1);
      flush_req = 1; rs1_rd_gnt = 1; rs1_rd_data = ~last_buf;
      @(posedge clk); #1;
      flush_req = 0; rs1_rd_gnt = 0; dec_i_valid = 0;
      #1;
      chk("flush_req_drop", {31'd0, rs1_rd_req}, 32'd0);
      chk("flush_wait", {31'd0, bpu_wait}, 32'd0);
      chk("flush_buf_keep", prdt_op1, last_buf);
      @(posedge clk); #1;
      chk("flush_idle", {31'd0, rs1_rd_req}, 32'd0);
      // reach CAPT without accepting, then reset asynchronously
      dec_jalr_rs1idx = 5'd9; dec_i_valid = 1;
      @(posedge clk); #1;
      rs1_rd_gnt = 1; rs1_rd_data = 32'hCAFE_0001;
      @(posedge clk); #1;
      rs1_rd_gnt = 0;
      chk("capt_wait", {31'd0, bpu_wait}, 32'd0);
      chk("capt_op1", prdt_op1, 32'hCAFE_0001);
      #1 rst_n = 0;
      #1;
      chk("arst_buf", prdt_op1, 32'd0);
      chk("arst_req", {31'd0, rs1_rd_req}, 32'd0);
      dec_i_valid = 0;
      #1;
      chk("arst_wait", {31'd0, bpu_wait}, 32'd0);
      @(negedge clk); rst_n = 1;
      @(posedge clk); #1;
      rs1_rd_gnt = 1; rs1_rd_data = 32'hBAD0_BAD0;
      @(posedge clk); #1;
      rs1_rd_gnt = 0;
      chk("stray_req", {31'd0, rs1_rd_req}, 32'd0);
      chk("stray_wait", {31'd0, bpu_wait}, 32'd0);
      chk("stray_buf", prdt_op1, 32'd0);
      issue(2, 5'd9, 32'h10, 32'h800, 0, 0, 0, 32'h0000_0F00);
      issue(0, 5'd0, 32'h24, 32'h900, 1, 0, 0, 0);
      @(posedge clk); #1;
      chk("queue_empty", exp_q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
